fifo_mwmr: RTL and testbench

//  Generalised multi-write / multi-read in-order FIFO for the commit stage.

---
 rtl/fifo_mwmr_if.sv | 32 +++
 rtl/fifo_mwmr.sv | 93 +++++++++
 tb/tb_fifo_mwmr.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_mwmr_if.sv
// Handshake bundle for the multi-write / multi-read commit FIFO.
// The master modport is the producer/consumer side, the slave modport is the FIFO.
interface fifo_mwmr_if #(
  parameter int QLEN  = 32,
  parameter int WIDTH = 64,
  parameter int WNUM  = 8,
  parameter int RNUM  = 2
);
  localparam int CW = $clog2(QLEN) + 1;

  logic                    flush;
  logic [WNUM-1:0]         valid;
  logic [WNUM*WIDTH-1:0]   write;
  logic                    write_ready;
  logic [RNUM-1:0]         read_valid;
  logic [RNUM*WIDTH-1:0]   read;
  logic [RNUM-1:0]         read_ready;
  logic [CW-1:0]           count;
  logic                    empty;
  logic                    full;
  logic                    overflow;

  modport master (
    output flush, valid, write, read_ready,
    input  write_ready, read_valid, read, count, empty, full, overflow
  );

  modport slave (
    input  flush, valid, write, read_ready,
    output write_ready, read_valid, read, count, empty, full, overflow
  );
endinterface

// File: rtl/fifo_mwmr.sv
// In-order FIFO taking up to WNUM sparse writes per cycle (compacted in port order)
// and presenting the RNUM oldest entries; the consumer pops a leading prefix of them.
module fifo_mwmr #(
  parameter int QLEN  = 32,
  parameter int WIDTH = 64,
  parameter int WNUM  = 8,
  parameter int RNUM  = 2
) (
  input  logic         clk,
  input  logic         reset,
  fifo_mwmr_if.slave   bus
);
  localparam int PW = $clog2(QLEN);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [QLEN];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_write_ready;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_n;
  logic [CW-1:0]    w_p;
  logic [PW-1:0]    w_off [WNUM];
  logic [RNUM-1:0]  w_read_valid;
  logic             w_run;

  // Readiness depends on registered occupancy only, so same-cycle pops never raise it.
  assign w_write_ready = (r_count <= CW'(QLEN - WNUM));
  assign w_push        = w_write_ready && !bus.flush;
  assign w_drop        = !w_write_ready && !bus.flush && (|bus.valid);

  // Each strobed port lands at tail plus the number of strobed ports below it.
  always_comb begin
    w_n = '0;
    for (int i = 0; i < WNUM; i++) begin
      w_off[i] = w_n[PW-1:0];
      if (bus.valid[i]) w_n = w_n + CW'(1);
    end
  end

  // Only the leading run of ready-and-valid slots is popped.
  always_comb begin
    w_p   = '0;
    w_run = 1'b1;
    for (int j = 0; j < RNUM; j++) begin
      w_read_valid[j] = (CW'(j) < r_count);
      if (w_run && w_read_valid[j] && bus.read_ready[j]) w_p = w_p + CW'(1);
      else                                               w_run = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + w_n[PW-1:0];
      r_head  <= r_head + w_p[PW-1:0];
      r_count <= r_count + (w_push ? w_n : '0) - w_p;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WNUM; i++) begin
      if (w_push && bus.valid[i]) r_mem[r_tail + w_off[i]] <= bus.write[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bus.read = '0;
    for (int j = 0; j < RNUM; j++) begin
      bus.read[j*WIDTH +: WIDTH] = r_mem[r_head + PW'(j)];
    end
  end

  assign bus.write_ready = w_write_ready;
  assign bus.read_valid  = w_read_valid;
  assign bus.count       = r_count;
  assign bus.empty       = (r_count == '0);
  assign bus.full        = (r_count == CW'(QLEN));
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_fifo_mwmr.sv
// Directed and randomized checks of fifo_mwmr against a queue-based reference model.
module tb_fifo_mwmr;
  localparam int QLEN  = 32;
  localparam int WIDTH = 64;
  localparam int WNUM  = 8;
  localparam int RNUM  = 2;

  typedef logic [WIDTH-1:0] dat_t;

  logic clk;
  logic reset;

  fifo_mwmr_if #(.QLEN(QLEN), .WIDTH(WIDTH), .WNUM(WNUM), .RNUM(RNUM)) bus ();

  fifo_mwmr #(.QLEN(QLEN), .WIDTH(WIDTH), .WNUM(WNUM), .RNUM(RNUM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dat_t q [$];
  bit   m_ovf;
  dat_t wd [WNUM];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [RNUM-1:0] rv;
    for (int j = 0; j < RNUM; j++) rv[j] = (j < q.size());
    check("count", 64'(bus.count), 64'(q.size()));
    check("empty", 64'(bus.empty), 64'(q.size() == 0));
    check("full", 64'(bus.full), 64'(q.size() == QLEN));
    check("write_ready", 64'(bus.write_ready), 64'((QLEN - q.size()) >= WNUM));
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
    check("read_valid", 64'(bus.read_valid), 64'(rv));
    for (int j = 0; j < RNUM; j++)
      if (j < q.size()) check("read_data", bus.read[j*WIDTH +: WIDTH], q[j]);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < WNUM; i++) wd[i] = {$urandom, $urandom};
  endtask

  task automatic drive(input logic [WNUM-1:0] v, input logic [RNUM-1:0] rr, input logic fl);
    bus.valid      = v;
    bus.read_ready = rr;
    bus.flush      = fl;
    for (int i = 0; i < WNUM; i++) bus.write[i*WIDTH +: WIDTH] = wd[i];
  endtask

  // Reference behaviour: the FIFO is a queue; a beat is all-or-nothing on free space.
  task automatic model_update();
    int  p;
    bit  go;
    bit  wr;
    if (bus.flush) begin
      q.delete();
      return;
    end
    wr = (QLEN - q.size()) >= WNUM;
    p  = 0;
    go = 1'b1;
    for (int j = 0; j < RNUM; j++) begin
      if (go && j < q.size() && bus.read_ready[j]) p++;
      else go = 1'b0;
    end
    repeat (p) void'(q.pop_front());
    if (wr) begin
      for (int i = 0; i < WNUM; i++)
        if (bus.valid[i]) q.push_back(bus.write[i*WIDTH +: WIDTH]);
    end else if (|bus.valid) begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    randomize_data();
    drive('0, '0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    q.delete();
    m_ovf = 1'b0;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    logic [RNUM-1:0] rr;
    logic [WNUM-1:0] v;

    reset = 1'b0;
    m_ovf = 1'b0;
    randomize_data();
    drive('0, '0, 1'b0);
    #23;
    check_all();
    reset = 1'b1;

    // sparse write compaction and single pop
    randomize_data();
    wd[2] = 64'hA; wd[5] = 64'hB; wd[7] = 64'hC;
    drive(8'b1010_0100, '0, 1'b0);
    step();
    check("t1_count", 64'(bus.count), 64'd3);
    check("t1_read0", bus.read[0 +: WIDTH], 64'hA);
    check("t1_read1", bus.read[WIDTH +: WIDTH], 64'hB);
    drive('0, 2'b01, 1'b0);
    step();
    check("t1_pop_read0", bus.read[0 +: WIDTH], 64'hB);
    check("t1_pop_read1", bus.read[WIDTH +: WIDTH], 64'hC);
    drive('0, 2'b11, 1'b0);
    step();

    // fill to full, then overflow on a single strobe
    repeat (3) begin drive(8'hFF, '0, 1'b0); step(); end
    check("t2_wr_at24", 64'(bus.write_ready), 64'd1);
    drive(8'hFF, '0, 1'b0);
    step();
    check("t2_full", 64'(bus.full), 64'd1);
    check("t2_wr_full", 64'(bus.write_ready), 64'd0);
    drive(8'h01, '0, 1'b0);
    step();
    check("t2_ovf", 64'(bus.overflow), 64'd1);
    check("t2_count", 64'(bus.count), 64'd32);

    // count 25: push is dropped even though the pop would make room
    pulse_reset();
    repeat (3) begin drive(8'hFF, '0, 1'b0); step(); end
    drive(8'h01, '0, 1'b0);
    step();
    drive(8'hFF, 2'b11, 1'b0);
    step();
    check("t3_count", 64'(bus.count), 64'd23);
    check("t3_ovf", 64'(bus.overflow), 64'd1);

    // move head to 28, then write across the wrap point
    drive('0, '0, 1'b1);
    step();
    repeat (14) begin drive(8'h03, 2'b11, 1'b0); step(); end
    drive('0, 2'b11, 1'b0);
    step();
    for (int i = 0; i < WNUM; i++) wd[i] = 64'hD0 + 64'(i);
    drive(8'hFF, '0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      check("t4_wrap0", bus.read[0 +: WIDTH], 64'hD0 + 64'(2*k));
      check("t4_wrap1", bus.read[WIDTH +: WIDTH], 64'hD1 + 64'(2*k));
      drive('0, 2'b11, 1'b0);
      step();
    end

    // flush wins over same-cycle writes and pops
    drive(8'hFF, '0, 1'b0); step();
    drive(8'h03, '0, 1'b0); step();
    check("t5_count_pre", 64'(bus.count), 64'd10);
    drive(8'hFF, 2'b11, 1'b1);
    step();
    check("t5_count", 64'(bus.count), 64'd0);
    check("t5_empty", 64'(bus.empty), 64'd1);
    check("t5_rv", 64'(bus.read_valid), 64'd0);
    check("t5_wr", 64'(bus.write_ready), 64'd1);

    // asynchronous reset mid-cycle
    drive(8'h1F, '0, 1'b0);
    step();
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check("t6_count", 64'(bus.count), 64'd0);
    check("t6_empty", 64'(bus.empty), 64'd1);
    check("t6_rv", 64'(bus.read_valid), 64'd0);
    check("t6_wr", 64'(bus.write_ready), 64'd1);
    check("t6_ovf", 64'(bus.overflow), 64'd0);
    #2;
    reset = 1'b1;
    drive(8'h10, '0, 1'b0);
    step();
    check("t6_after", 64'(bus.count), 64'd1);

    // random traffic, including non-prefix read_ready and occasional flush
    pulse_reset();
    for (int c = 0; c < 800; c++) begin
      randomize_data();
      v = ($urandom_range(0, 2) == 0) ? WNUM'($urandom) : '0;
      case ($urandom_range(0, 4))
        0:       rr = 2'b00;
        1:       rr = 2'b01;
        2:       rr = 2'b10;
        default: rr = 2'b11;
      endcase
      drive(v, rr, ($urandom_range(0, 39) == 0));
      step();
      if (c == 400) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
